// File: rtl/rv_pkg.sv
// Shared register-file widths and the writeback request payload.
package rv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    // Destination x0 is hard-wired zero; writes to it are discarded.
    function automatic logic is_real_rd(input logic [REG_AW-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// FIFO of writeback requests with a per-entry valid vector so the
// owner can build a pending-destination mask from the stored entries.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_req_t                          push_req,
    input  logic                             pop,
    output wb_req_t                          head,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [DEPTH-1:0]                 entry_valid,
    output wb_req_t                          entries [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    wb_req_t          mem [DEPTH];

    // Occupancy comes from count alone, so equal pointers are never ambiguous.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (push_ok) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage needs no reset; entry_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_req;
        end
    end

endmodule

// File: rtl/rf_writeback_arb.sv
// Writeback arbiter feeding the regfile write port: ALU results win unless the
// queued LSU head has starved. Optional same-cycle read bypass via RF_WB_BYPASS_EN.
module rf_writeback_arb
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic [NREGS-1:0]  pend_mask,
    output logic              WE,
    output logic [REG_AW-1:0] A3,
    output logic [XLEN-1:0]   WD3
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [REG_AW-1:0] byp_a1,
    input  logic [REG_AW-1:0] byp_a2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [XLEN-1:0]   byp_d1,
    output logic [XLEN-1:0]   byp_d2
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  q_count_next;
    logic [DEPTH-1:0]  q_valid;
    wb_req_t           q_head;
    wb_req_t           q_entries [DEPTH];
    wb_req_t           push_req;

    logic [AGE_W-1:0]  age;
    logic              force_pop;
    logic              wr_en;
    wb_req_t           wr_req;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (q_push),
        .push_req    (push_req),
        .pop         (q_pop),
        .head        (q_head),
        .full        (q_full),
        .empty       (q_empty),
        .count       (q_count),
        .entry_valid (q_valid),
        .entries     (q_entries)
    );

    // Writes to x0 are accepted from the LSU but never queued.
    assign push_req.rd   = lsu_rd;
    assign push_req.data = lsu_data;
    assign q_push        = lsu_valid && lsu_ready && is_real_rd(lsu_rd);

    // Arbitration looks only at registered queue state plus the ALU request.
    assign force_pop = (age == AGE_W'(STARVE_MAX)) && !q_empty;
    assign alu_stall = force_pop && alu_valid;

    always_comb begin
        q_pop  = 1'b0;
        wr_en  = 1'b0;
        wr_req = '0;
        if (force_pop) begin
            q_pop  = 1'b1;
            wr_en  = 1'b1;
            wr_req = q_head;
        end else if (alu_valid && is_real_rd(alu_rd)) begin
            wr_en       = 1'b1;
            wr_req.rd   = alu_rd;
            wr_req.data = alu_data;
        end else if (!q_empty) begin
            q_pop  = 1'b1;
            wr_en  = 1'b1;
            wr_req = q_head;
        end
    end

    assign q_count_next = q_count + CNT_W'(q_push) - CNT_W'(q_pop);

    // lsu_ready is a register so it reads 0 throughout reset and has no lsu_* path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_ready <= 1'b0;
        end else begin
            lsu_ready <= (q_count_next != CNT_W'(DEPTH));
        end
    end

    // Head age: cleared when the queue is empty or the head leaves, saturating otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (q_empty || q_pop) begin
            age <= '0;
        end else if (age != AGE_W'(STARVE_MAX)) begin
            age <= age + AGE_W'(1);
        end
    end

    // Regfile write port register; address/data hold when no write is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE  <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE <= wr_en;
            if (wr_en) begin
                A3  <= wr_req.rd;
                WD3 <= wr_req.data;
            end
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (q_valid[i]) begin
                pend_mask[q_entries[i].rd] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

`ifdef RF_WB_BYPASS_EN
    // Forward the write in flight to readers in the same cycle.
    assign byp_hit1 = WE && (A3 == byp_a1) && is_real_rd(byp_a1);
    assign byp_hit2 = WE && (A3 == byp_a2) && is_real_rd(byp_a2);
    assign byp_d1   = WD3;
    assign byp_d2   = WD3;
`endif

endmodule

// File: tb/tb_rf_writeback_arb.sv
// Randomized bench for rf_writeback_arb against a queue-based reference model.
module tb_rf_writeback_arb;
    import rv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int SM = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [31:0]       alu_data;
    logic              alu_stall;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [4:0]        lsu_rd;
    logic [31:0]       lsu_data;
    logic [31:0]       pend_mask;
    logic              WE;
    logic [4:0]        A3;
    logic [31:0]       WD3;

    int checks   = 0;
    int failures = 0;

    wb_req_t     mq [$];
    int          m_age;
    logic        m_ready;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;

    rf_writeback_arb #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .pend_mask (pend_mask),
        .WE        (WE),
        .A3        (A3),
        .WD3       (WD3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_age   = 0;
        m_ready = 1'b0;
        m_we    = 1'b0;
        m_a3    = '0;
        m_wd3   = '0;
    endtask

    // One clock: drive at posedge+1, check combinational/registered state, advance model.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        output logic stalled);
        bit          emp;
        bit          frc;
        bit          popped;
        bit          wr;
        logic [4:0]  a3;
        logic [31:0] wd;
        wb_req_t     r;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        #1;
        emp = (mq.size() == 0);
        frc = (m_age == SM) && !emp;
        check("alu_stall", 32'(alu_stall), 32'(frc && av));
        check("lsu_ready", 32'(lsu_ready), 32'(m_ready));
        check("pend_mask", pend_mask, model_mask());
        stalled = alu_stall;
        popped = 0; wr = 0; a3 = '0; wd = '0;
        if (frc || (!(av && ard != 0) && !emp)) begin
            wr = 1; a3 = mq[0].rd; wd = mq[0].data; popped = 1;
        end else if (av && ard != 0) begin
            wr = 1; a3 = ard; wd = ad;
        end
        if (popped) void'(mq.pop_front());
        if (lv && m_ready && lrd != 0) begin
            r.rd = lrd; r.data = ld;
            mq.push_back(r);
        end
        m_age   = (popped || emp) ? 0 : ((m_age < SM) ? m_age + 1 : SM);
        m_ready = (mq.size() < DEPTH);
        m_we    = wr;
        if (wr) begin m_a3 = a3; m_wd3 = wd; end
        @(posedge clk); #1;
        check("WE", 32'(WE), 32'(m_we));
        check("A3", 32'(A3), 32'(m_a3));
        check("WD3", WD3, m_wd3);
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, s);
    endtask

    initial begin
        logic        s;
        int          stalls;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;

        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_WE", 32'(WE), 0);
        check("rst_A3", 32'(A3), 0);
        check("rst_WD3", WD3, 0);
        check("rst_lsu_ready", 32'(lsu_ready), 0);
        check("rst_alu_stall", 32'(alu_stall), 0);
        check("rst_pend_mask", pend_mask, 0);
        rst = 1'b0;

        idle(1);
        // ALU-only write lands one cycle later
        step(1, 5, 32'h1234_5678, 0, 0, 0, s);
        check("t1_WE", 32'(WE), 1);
        check("t1_A3", 32'(A3), 5);
        check("t1_WD3", WD3, 32'h1234_5678);

        // rd=0 from both sources: no write, nothing queued
        step(1, 0, 32'hdead_beef, 1, 0, 32'hcafe_f00d, s);
        check("t2_WE", 32'(WE), 0);
        idle(1);
        check("t2_pend", pend_mask, 0);

        // Fill queue with rd 1..4 while ALU keeps winning
        for (int i = 1; i <= 4; i++) step(1, 20, 32'(100 + i), 1, 5'(i), 32'(i), s);
        #1;
        check("t3_ready", 32'(lsu_ready), 0);
        check("t3_pend", pend_mask, 32'h1E);

        // Continuous ALU traffic: exactly one forced pop in the next 12 cycles
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 21, 32'(200 + i), 0, 0, 0, s);
            if (s) begin
                stalls++;
                check("t4_A3", 32'(A3), 1);
            end
        end
        check("t4_stalls", 32'(stalls), 1);
        idle(6);
        check("t4_drained", pend_mask, 0);

        // Push+pop with two entries queued
        step(1, 22, 1, 1, 7, 32'h77, s);
        step(1, 22, 2, 1, 8, 32'h88, s);
        step(0, 0, 0, 1, 9, 32'h99, s);
        check("t5_A3", 32'(A3), 7);
        idle(1);
        check("t5_pend", pend_mask, 32'h0000_0200);
        idle(2);

        // Reset mid-operation with three queued and a write in flight
        for (int i = 0; i < 3; i++) step(1, 23, 32'(i), 1, 5'(10 + i), 32'(i), s);
        step(1, 24, 32'h5555, 0, 0, 0, s);
        #2 rst = 1'b1;
        #1;
        check("t6_WE", 32'(WE), 0);
        check("t6_ready", 32'(lsu_ready), 0);
        check("t6_pend", pend_mask, 0);
        model_reset();
        alu_valid = 0; lsu_valid = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);

        // Random traffic; ALU request held stable while stalled
        av = 0; ard = 0; ad = 0; s = 0;
        for (int i = 0; i < 800; i++) begin
            if (!s) begin
                av  = ($urandom_range(0, 9) < 7);
                ard = 5'($urandom_range(0, 7));
                ad  = $urandom;
            end
            step(av, ard, ad, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
